// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter onto a single memory
// port, with a per-access timeout that completes the transaction with an error.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_q;      // 1 = data port was granted last
    logic              gid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic              mem_en_q;
    logic              mem_we_q;

    logic grant_fetch;
    logic grant_data;
    logic timeout_hit;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant_fetch = if_req && (!d_req || last_q);
        grant_data  = d_req && !grant_fetch;
        timeout_hit = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (if_req || d_req) state_d = ACCESS;
            ACCESS:  if (mem_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q   <= 1'b1;
            gid_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_fetch) begin
                        gid_q    <= 1'b0;
                        last_q   <= 1'b0;
                        addr_q   <= if_addr;
                        we_q     <= 1'b0;
                        wdata_q  <= '0;
                        wmask_q  <= '0;
                        cnt_q    <= '0;
                        mem_en_q <= 1'b1;
                        mem_we_q <= 1'b0;
                    end else if (grant_data) begin
                        gid_q    <= 1'b1;
                        last_q   <= 1'b1;
                        addr_q   <= d_addr;
                        we_q     <= d_we;
                        wdata_q  <= d_wdata;
                        wmask_q  <= d_wmask;
                        cnt_q    <= '0;
                        mem_en_q <= 1'b1;
                        mem_we_q <= d_we;
                    end
                end
                ACCESS: begin
                    // mem_ready takes priority over an expiry in the same cycle.
                    if (mem_ready) begin
                        rdata_q  <= we_q ? '0 : mem_rdata;
                        err_q    <= 1'b0;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q  <= '0;
                        err_q    <= 1'b1;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        grant_id  = gid_q;
        if_done   = (state_q == RESP) && !gid_q;
        d_done    = (state_q == RESP) && gid_q;
        if_err    = if_done && err_q;
        d_err     = d_done && err_q;
        if_rdata  = if_done ? rdata_q : '0;
        d_rdata   = d_done ? rdata_q : '0;
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
    end

endmodule
